// File: rtl/switch_wishbone.sv
// Wishbone read-side peripheral for board switches/buttons: 2-FF sync, per-bit debounce,
// sticky write-1-to-clear rising-edge flags and a maskable level interrupt.
module switch_wishbone #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEBOUNCE = 5000
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             STB_I,
    input  logic             WE_I,
    input  logic [31:0]      ADR_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    output logic             ACK_O,
    output logic             INT_O,
    input  logic [WIDTH-1:0] I_pins
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CntMax   = CW'(DEBOUNCE - 1);
    localparam logic [31:0]   IdValue  = 32'h5357_0000 | 32'(WIDTH);
    localparam logic [1:0]    RegState = 2'd0;
    localparam logic [1:0]    RegEdge  = 2'd1;
    localparam logic [1:0]    RegIrq   = 2'd2;
    localparam logic [1:0]    RegId    = 2'd3;

    logic [WIDTH-1:0]          sync1_q, sync2_q;
    logic [WIDTH-1:0]          state_q, state_d;
    logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]          edge_q, edge_d;
    logic [WIDTH-1:0]          irq_en_q, irq_en_d;
    logic [WIDTH-1:0]          clr;
    logic [31:0]               rdata, dat_q, dat_d;
    logic                      ack_q;
    logic                      access, wr;
    logic                      unused_bits;

    // A new access is accepted only when no ACK is currently being returned.
    assign access = STB_I & ~ack_q;
    assign wr     = access & WE_I;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                state_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A rising edge in the same cycle as a clear of that bit leaves the flag set.
    always_comb begin
        clr      = (wr && ADR_I[3:2] == RegEdge) ? DAT_I[WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~clr) | (state_d & ~state_q);
        irq_en_d = (wr && ADR_I[3:2] == RegIrq) ? DAT_I[WIDTH-1:0] : irq_en_q;
    end

    always_comb begin
        rdata = '0;
        unique case (ADR_I[3:2])
            RegState: rdata[WIDTH-1:0] = state_q;
            RegEdge:  rdata[WIDTH-1:0] = edge_q;
            RegIrq:   rdata[WIDTH-1:0] = irq_en_q;
            RegId:    rdata            = IdValue;
            default:  rdata            = '0;
        endcase
        dat_d = access ? rdata : '0;
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            dat_q    <= '0;
            ack_q    <= 1'b0;
        end else begin
            sync1_q  <= I_pins;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            irq_en_q <= irq_en_d;
            dat_q    <= dat_d;
            ack_q    <= access;
        end
    end

    assign DAT_O       = dat_q;
    assign ACK_O       = ack_q;
    assign INT_O       = |(edge_q & irq_en_q);
    assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], DAT_I};

endmodule
